// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - four-digit packed-BCD up/down counter with prescaler; optional saturation via BCD_SAT_EN
module bcd_counter4 #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] bits,
  output logic        tick,
  output logic        wrap
);

  // Number of clk cycles per automatic count.
  localparam int DIV = CLK_HZ / TICK_HZ;
  // Prescaler width; guarded so an illegal DIV cannot produce a zero-width vector.
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

`ifdef BCD_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // A divider below 2 would make every cycle a terminal count; refuse to build.
  generate
    if (DIV < 2) begin : g_div_check
      $error("bcd_counter4: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   bits_q, bits_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic          pre_tc;
  logic          adv;
  logic [15:0]   inc_val;
  logic [15:0]   dec_val;
  logic [15:0]   load_clamped;
  logic          at_max;
  logic          at_min;
  logic          carry;
  logic          borrow;

  // Terminal count of the prescaler and the merged advance request.
  // A step landing on the terminal count still yields only one advance.
  always_comb begin
    pre_tc = (pre_q == PRE_TC);
    adv    = (en && pre_tc) || step;
  end

  // BCD increment with ripple carry, resolved across all four digits in one cycle.
  always_comb begin
    inc_val = bits_q;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (bits_q[i*4 +: 4] == 4'd9) begin
          inc_val[i*4 +: 4] = 4'd0;
        end else begin
          inc_val[i*4 +: 4] = 4'(bits_q[i*4 +: 4] + 4'd1);
          carry             = 1'b0;
        end
      end
    end
  end

  // BCD decrement with ripple borrow, resolved across all four digits in one cycle.
  always_comb begin
    dec_val = bits_q;
    borrow  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (bits_q[i*4 +: 4] == 4'd0) begin
          dec_val[i*4 +: 4] = 4'd9;
        end else begin
          dec_val[i*4 +: 4] = 4'(bits_q[i*4 +: 4] - 4'd1);
          borrow            = 1'b0;
        end
      end
    end
  end

  // Clamp each nibble of the load value to 9 so bits can never hold a non-BCD digit.
  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < 4; i++) begin
      if (load_val[i*4 +: 4] > 4'd9) begin
        load_clamped[i*4 +: 4] = 4'd9;
      end
    end
  end

  // Range-edge detection used for wrap reporting and saturation.
  always_comb begin
    at_max = (bits_q == 16'h9999);
    at_min = (bits_q == 16'h0000);
  end

  // Prescaler next state: cleared by clr/load, holds while disabled, else counts modulo DIV.
  always_comb begin
    pre_d = pre_q;
    if (clr || load) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_tc) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Counter next state with priority clr > load > advance; up is only looked at on advances.
  always_comb begin
    bits_d = bits_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clr) begin
      bits_d = 16'h0000;
    end else if (load) begin
      bits_d = load_clamped;
    end else if (adv) begin
      tick_d = 1'b1;
      if (up) begin
        if (at_max && SAT_EN) begin
          bits_d = bits_q;
        end else begin
          bits_d = inc_val;
          wrap_d = at_max;
        end
      end else begin
        if (at_min && SAT_EN) begin
          bits_d = bits_q;
        end else begin
          bits_d = dec_val;
          wrap_d = at_min;
        end
      end
    end
  end

  // State registers; reset drops everything to zero immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      bits_q <= 16'h0000;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      bits_q <= bits_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign bits = bits_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter4.sv
// tb/tb_bcd_counter4.sv - randomized self-checking bench for bcd_counter4 against a decimal reference model
module tb_bcd_counter4;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic        clr = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic        step = 1'b0;
  logic [15:0] bits;
  logic        tick;
  logic        wrap;

  int checks = 0;
  int failures = 0;

  // reference model state: count as a plain decimal integer
  int m_val = 0;
  int m_pre = 0;
  bit m_tick = 1'b0;
  bit m_wrap = 1'b0;

  bcd_counter4 #(.CLK_HZ(100), .TICK_HZ(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .step(step), .bits(bits), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int clamp_decode(input logic [15:0] b);
    int s = 0;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(b[i*4 +: 4]);
      if (d > 9) d = 9;
      s = s * 10 + d;
    end
    return s;
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    bit tc;
    bit adv;
    m_tick = 0;
    m_wrap = 0;
    if (!rst) begin
      model_reset();
    end else if (clr) begin
      m_val = 0; m_pre = 0;
    end else if (load) begin
      m_val = clamp_decode(load_val); m_pre = 0;
    end else begin
      tc  = en && (m_pre == DIV - 1);
      adv = tc || step;
      if (en) m_pre = tc ? 0 : m_pre + 1;
      if (adv) begin
        m_tick = 1;
`ifdef BCD_SAT_EN
        if (up) m_val = (m_val == 9999) ? 9999 : m_val + 1;
        else    m_val = (m_val == 0) ? 0 : m_val - 1;
`else
        if (up) begin
          m_wrap = (m_val == 9999);
          m_val  = (m_val + 1) % 10000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 9999) % 10000;
        end
`endif
      end
    end
  endtask

  // one clock: inputs already set by caller, advance model at the edge, compare 1 ns later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("bits", {16'h0, bits}, {16'h0, to_bcd(m_val)});
    check_eq("tick", {31'h0, tick}, {31'h0, m_tick});
    check_eq("wrap", {31'h0, wrap}, {31'h0, m_wrap});
  endtask

  initial begin
    int n;
    int got;
    // reset state
    #12;
    check_eq("rst_bits", {16'h0, bits}, 32'h0);
    check_eq("rst_tick", {31'h0, tick}, 32'h0);
    check_eq("rst_wrap", {31'h0, wrap}, 32'h0);
    #8;
    rst = 1'b1;
    en = 1'b1;
    up = 1'b1;
    model_reset();

    // first tick after DIV edges, then 0010 after 100
    for (n = 1; n <= 100; n++) begin
      cycle();
      if (n == 9)   check_eq("pre_first_bits", {16'h0, bits}, 32'h0000);
      if (n == 10) begin
        check_eq("first_bits", {16'h0, bits}, 32'h0001);
        check_eq("first_tick", {31'h0, tick}, 32'h1);
      end
      if (n == 11)  check_eq("first_tick_len", {31'h0, tick}, 32'h0);
      if (n == 100) check_eq("hundred_bits", {16'h0, bits}, 32'h0010);
    end

    // up wrap
    load = 1'b1; load_val = 16'h9998;
    cycle();
    load = 1'b0;
    for (n = 1; n <= 20; n++) begin
      cycle();
      if (n == 10) check_eq("upwrap_9999", {16'h0, bits}, 32'h9999);
      if (n == 20) begin
`ifdef BCD_SAT_EN
        check_eq("upwrap_bits", {16'h0, bits}, 32'h9999);
        check_eq("upwrap_wrap", {31'h0, wrap}, 32'h0);
`else
        check_eq("upwrap_bits", {16'h0, bits}, 32'h0000);
        check_eq("upwrap_wrap", {31'h0, wrap}, 32'h1);
`endif
        check_eq("upwrap_tick", {31'h0, tick}, 32'h1);
      end
    end

    // down borrow
    en = 1'b0; up = 1'b0;
    load = 1'b1; load_val = 16'h1000; cycle();
    load = 1'b0; step = 1'b1; cycle();
    step = 1'b0;
    check_eq("borrow_bits", {16'h0, bits}, 32'h0999);
    load = 1'b1; load_val = 16'h0000; cycle();
    load = 1'b0; step = 1'b1; cycle();
    step = 1'b0;
`ifdef BCD_SAT_EN
    check_eq("downwrap_bits", {16'h0, bits}, 32'h0000);
    check_eq("downwrap_wrap", {31'h0, wrap}, 32'h0);
`else
    check_eq("downwrap_bits", {16'h0, bits}, 32'h9999);
    check_eq("downwrap_wrap", {31'h0, wrap}, 32'h1);
`endif

    // load clamp and priority
    load = 1'b1; load_val = 16'hABCD; cycle();
    check_eq("clamp_bits", {16'h0, bits}, 32'h9999);
    clr = 1'b1; cycle();
    clr = 1'b0;
    check_eq("clr_over_load", {16'h0, bits}, 32'h0000);
    load_val = 16'h1234; step = 1'b1; cycle();
    check_eq("load_over_step", {16'h0, bits}, 32'h1234);
    check_eq("load_no_tick", {31'h0, tick}, 32'h0);
    load = 1'b0; step = 1'b0;

    // enable hold: 4 cycles in, freeze 50, then the remaining 6 produce the tick
    up = 1'b1; en = 1'b1;
    for (n = 0; n < 4; n++) cycle();
    en = 1'b0;
    for (n = 0; n < 50; n++) cycle();
    check_eq("hold_bits", {16'h0, bits}, 32'h1234);
    en = 1'b1;
    got = 0;
    for (n = 1; n <= 20 && got == 0; n++) begin
      cycle();
      if (tick) got = n;
    end
    check_eq("resume_latency", got, 6);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 299) != 0);
      en   = ($urandom_range(0, 9) != 0);
      up   = $urandom_range(0, 1);
      clr  = ($urandom_range(0, 59) == 0);
      load = ($urandom_range(0, 29) == 0);
      step = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: load_val = 16'h9999;
        1: load_val = 16'h0000;
        2: load_val = 16'h9998;
        3: load_val = 16'h0001;
        default: load_val = 16'($urandom);
      endcase
      cycle();
    end
    rst = 1'b1; clr = 1'b0; load = 1'b0; step = 1'b0; en = 1'b0;
    cycle();

    // async reset mid-operation with tick high
    up = 1'b1;
    load = 1'b1; load_val = 16'h0455; cycle();
    load = 1'b0; step = 1'b1; cycle();
    step = 1'b0;
    check_eq("pre_areset_bits", {16'h0, bits}, 32'h0456);
    #2;
    rst = 1'b0;
    #1;
    check_eq("areset_bits", {16'h0, bits}, 32'h0000);
    check_eq("areset_tick", {31'h0, tick}, 32'h0);
    check_eq("areset_wrap", {31'h0, wrap}, 32'h0);
    model_reset();
    cycle();
    rst = 1'b1; en = 1'b1;
    for (n = 0; n < 25; n++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_counter4.md
Name: bcd_counter4

Overview:
- Four-digit packed-BCD up/down counter that generates the 16-bit `bits` word consumed directly by the 8-digit seg7 scanner.
- Digit 0 (least significant) is `bits[3:0]`; digit 3 is `bits[15:12]`.
- An internal prescaler derives a count tick from the 100 MHz board clock.
- Switch and button logic drives enable, direction, load, clear and single-step.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 10, count rate in Hz.
- DIV = CLK_HZ/TICK_HZ is a derived localparam. DIV must be ≥ 2, checked at elaboration.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  prescaler/count enable.
- up  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear to 0000.
- load  input  1  synchronous load of load_val.
- load_val  input  16  packed BCD value to load.
- step  input  1  one-cycle pulse; advances the counter by one in the current direction.
- bits  output  16  packed BCD count, registered.
- tick  output  1  one-cycle pulse, coincident with each count update.
- wrap  output  1  one-cycle pulse, coincident with a 9999→0000 or 0000→9999 transition.

Behaviour:
- **Clock and reset:** one clock domain, `clk`. Reset is asynchronous, active-low on `rst`.
  - While `rst`=0: bits=16'h0000, tick=0, wrap=0, prescaler=0.
- **Prescaler:** counts 0..DIV-1 while `en`=1 and holds while `en`=0. It returns to 0 after DIV-1.
  - Internal advance request `adv` = (en && prescaler==DIV-1) || step.
- **Priority each cycle:** clr > load > adv.
  - clr: bits←0000, prescaler←0, tick=0, wrap=0.
  - load: each nibble of load_val greater than 9 is loaded as 9; prescaler←0; tick=0; wrap=0.
  - adv with up=1: BCD increment with ripple carry, fully resolved in one cycle. Digit 9 becomes 0 and carries into the next digit. 9999 becomes 0000 and sets wrap.
  - adv with up=0: BCD decrement with ripple borrow. Digit 0 becomes 9 and borrows. 0000 becomes 9999 and sets wrap.
- **Multiple advances:** step and a prescaler terminal count in the same cycle produce a single advance, not two.
- **Output timing:**
  - tick and wrap are registered. They are high for exactly the one cycle in which the new bits value is first visible.
  - Latency: bits changes on the rising edge where adv was sampled high.
- **Direction changes:** `up` is sampled only on advance cycles. Changing it mid-period does not reset the prescaler.
- **Value invariant:** bits never holds a nibble greater than 9 under any input sequence.
- **Reset mid-period:** returns to the reset state immediately; counting resumes from 0000 with a full DIV-cycle period.
- **Input conditioning:** inputs are synchronous to clk. Debouncing and synchronising of buttons is done upstream.

Optional Feature:
- Macro: BCD_SAT_EN.
- When defined:
  - The counter saturates: up at 9999 holds 9999, and down at 0000 holds 0000.
  - wrap is never asserted.
  - tick is still asserted on every adv, including saturated holds.
- When undefined: wrap-around behaviour exactly as described in Behaviour.

Test Plan:
- **Reset and first tick:** CLK_HZ=100, TICK_HZ=10 (DIV=10). rst low 20 ns then high, en=1, up=1 → bits=0000 until the 10th rising edge after release. bits=0001 with tick=1 for one cycle. bits=0010 after 100 edges.
- **Up wrap:** load load_val=16'h9998, en=1, up=1 → 9999 after 10 cycles. Then 0000 with tick=1 and wrap=1 in the same cycle. With BCD_SAT_EN: stays 9999 and wrap=0.
- **Down borrow:** load 16'h1000, up=0, pulse step → bits=0999. Load 16'h0000, pulse step → 9999 with wrap=1.
- **Load clamp and priority:** load_val=16'hABCD, load=1 → bits=16'h9999. Assert clr and load together → 0000. load with step in the same cycle → loaded value, no advance.
- **Enable hold:** en=0 for 50 cycles mid-count → bits and prescaler frozen. Re-enable → next tick arrives after the remaining prescaler count, not after a fresh DIV.
- **Async reset mid-operation:** drive rst low between clock edges at bits=16'h0456 → bits=0000 before the next clock edge. tick and wrap go low immediately.
